// File: rtl/if_fetch_pkg.sv
// Shared pipeline package.
// Holds the instruction-fetch FSM encoding, the reset PC that is shared
// with the next-PC logic, and a small word-address increment helper.
package if_fetch_pkg;

  // Fetch FSM state encoding.
  localparam logic [1:0] ST_REQ  = 2'd0;  // request outstanding for PC
  localparam logic [1:0] ST_DROP = 2'd1;  // outstanding request is wrong-path
  localparam logic [1:0] ST_HOLD = 2'd2;  // fetched word parked while stalled

  // Byte address of the first fetch after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Next sequential word address. Wraps modulo 2^30.
  function automatic logic [29:0] word_inc(input logic [29:0] addr);
    return addr + 30'd1;
  endfunction

endpackage

// File: rtl/if_fetch_id_reg.sv
// IF/ID pipeline register.
// Holds {ins, pc_plus_4, valid}. Control priority is hold > load > bubble.
// A bubble only clears valid; the stale payload is meaningless once valid=0.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   hold              keep the current contents
//   load              capture ins_in / pc_plus_4_in as a valid instruction
//   bubble            mark the register empty
//   ins_in            instruction to load
//   pc_plus_4_in      word address of the following instruction
//   ins, pc_plus_4    registered instruction and following address
//   valid             1 = real instruction, 0 = bubble
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] ins_in,
  input  logic [29:0] pc_plus_4_in,
  output logic [31:0] ins,
  output logic [29:0] pc_plus_4,
  output logic        valid
);

  logic [31:0] ins_q, ins_d;
  logic [29:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    ins_d   = ins_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (hold) begin
      // keep everything
    end else if (load) begin
      ins_d   = ins_in;
      pc4_d   = pc_plus_4_in;
      valid_d = 1'b1;
    end else if (bubble) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_q   <= 32'd0;
      pc4_q   <= 30'd0;
      valid_q <= 1'b0;
    end else begin
      ins_q   <= ins_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign ins       = ins_q;
  assign pc_plus_4 = pc4_q;
  assign valid     = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage.
// Owns the PC, issues one word fetch at a time over a req/ack handshake,
// parks a fetched word in a skid buffer while stalled, and squashes the
// wrong-path fetch when ID redirects.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   PC                current fetch word address (to next-PC logic)
//   NPC               next word address from next-PC logic
//   flush             ID resolved a taken branch/jump
//   stall             hazard unit holds IF/ID and PC
//   imem_req/addr     fetch request and word address
//   imem_ack/rdata    one-cycle response pulse and instruction
//   id_ins, id_PC_plus_4, id_valid   IF/ID register outputs
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] PC,
  input  logic [29:0] NPC,
  input  logic        flush,
  input  logic        stall,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_ins,
  output logic [29:0] id_PC_plus_4,
  output logic        id_valid
);

  localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

  logic [1:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [29:0] redir_q, redir_d;

  logic        fl;
  logic        ack_v;
  logic        id_load, id_hold, id_bubble;
  logic [31:0] id_load_ins;

  // A stalled ID has not resolved its branch, so flush only counts unstalled.
  assign fl       = flush & ~stall;
  assign imem_req = (state_q == ST_REQ) | (state_q == ST_DROP);
  // Acks arriving with no request outstanding are ignored.
  assign ack_v    = imem_ack & imem_req;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    skid_d      = skid_q;
    redir_d     = redir_q;
    id_load     = 1'b0;
    id_hold     = 1'b0;
    id_bubble   = 1'b0;
    id_load_ins = imem_rdata;
    case (state_q)
      ST_REQ: begin
        if (ack_v) begin
          if (fl) begin
            pc_d      = NPC;
            id_bubble = 1'b1;
          end else if (stall) begin
            skid_d  = imem_rdata;
            state_d = ST_HOLD;
            id_hold = 1'b1;
          end else begin
            id_load = 1'b1;
            pc_d    = NPC;
          end
        end else begin
          if (fl) begin
            // Response still in flight; remember where to go once it lands.
            redir_d   = NPC;
            state_d   = ST_DROP;
            id_bubble = 1'b1;
          end else if (stall) begin
            id_hold = 1'b1;
          end else begin
            id_bubble = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (stall) id_hold = 1'b1;
        else       id_bubble = 1'b1;
        if (fl) redir_d = NPC;
        if (ack_v) begin
          // A flush in the same cycle as the stale ack is the newer target.
          pc_d    = fl ? NPC : redir_q;
          state_d = ST_REQ;
        end
      end
      ST_HOLD: begin
        id_load_ins = skid_q;
        if (stall) begin
          id_hold = 1'b1;
        end else if (fl) begin
          pc_d      = NPC;
          id_bubble = 1'b1;
          state_d   = ST_REQ;
        end else begin
          id_load = 1'b1;
          pc_d    = NPC;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d   = ST_REQ;
        id_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_WORD;
      skid_q  <= 32'd0;
      redir_q <= 30'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      skid_q  <= skid_d;
      redir_q <= redir_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst          (rst),
    .hold         (id_hold),
    .load         (id_load),
    .bubble       (id_bubble),
    .ins_in       (id_load_ins),
    .pc_plus_4_in (word_inc(pc_q)),
    .ins          (id_ins),
    .pc_plus_4    (id_PC_plus_4),
    .valid        (id_valid)
  );

  assign PC        = pc_q;
  assign imem_addr = pc_q;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the 5-stage MIPS pipeline. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It loads the IF/ID pipeline register and takes the next-PC value from the next-PC logic, which reads the PC this block drives. It also honours hazard-unit stalls and squashes wrong-path fetches when ID resolves a taken branch or jump.

## Interface
Parameters:
- RESET_PC, default 32'h0000_3000: byte address of the first fetch; bits [1:0] are ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- PC  out  30 [31:2]  current fetch word address, fed to the next-PC logic.
- NPC  in  30 [31:2]  next word address from the next-PC logic; equals PC+1 unless ID is redirecting.
- flush  in  1  taken branch/jump resolved in ID; the current IF instruction is wrong-path.
- stall  in  1  hazard unit holds IF/ID and PC.
- imem_req  out  1  fetch request.
- imem_addr  out  30 [31:2]  fetch word address.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- id_ins  out  32  IF/ID instruction.
- id_PC_plus_4  out  30 [31:2]  IF/ID address of the following instruction.
- id_valid  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- Effective flush: fl = flush & ~stall. While stalled, the branch in ID is not resolved, so flush is ignored.
- States:
  - REQ: request outstanding for PC.
  - DROP: an outstanding request is wrong-path; its response will be discarded.
  - HOLD: a fetched instruction is parked in the skid buffer while stall=1.
- imem_req = (state==REQ | state==DROP). imem_addr = PC.
- PC changes only on ack, in HOLD, or on a flush. The address is therefore stable until ack.
- At most one request outstanding. An ack while imem_req=0 is ignored.
- REQ, ack=1:
  - fl: discard rdata. PC<=NPC. IF/ID bubble. Stay in REQ.
  - stall: buf<=rdata. Go to HOLD. PC and IF/ID hold.
  - otherwise: IF/ID<={rdata, PC+1, 1}. PC<=NPC.
- REQ, ack=0:
  - fl: redir<=NPC. Go to DROP. IF/ID bubble.
  - stall: IF/ID holds.
  - otherwise: IF/ID bubble.
- DROP:
  - IF/ID is a bubble unless stall=1, in which case it holds.
  - A further flush overwrites redir.
  - On ack: discard rdata. PC<=redir. Go to REQ.
- HOLD:
  - stall=1: everything holds.
  - fl: discard buf. PC<=NPC. IF/ID bubble. Go to REQ.
  - otherwise: IF/ID<={buf, PC+1, 1}. PC<=NPC. Go to REQ.
- PC+1 wraps modulo 2^30.

## Timing
- Reset values:
  - PC = RESET_PC[31:2], state REQ.
  - imem_req = 1, combinational from state, so it is asserted during reset as well.
  - id_valid = 0, id_ins = 0, id_PC_plus_4 = 0, buf = 0, redir = 0.
- Reset asserted mid-fetch aborts immediately. A late ack after reset deassertion is indistinguishable from the new request's ack. The memory model must therefore also be reset by rst.
- Latency from ack to id_valid is 1 clock, on the edge that samples ack. With zero-wait memory (ack in the same cycle as req), throughput is 1 instruction/cycle.
- Leaving HOLD costs one idle request cycle.
- A flush squashes exactly one IF slot. The redirect target is fetched on the next request after the stale ack.

## Structure
- Shared pipeline package holds:
  - the state encoding (REQ=2'd0, DROP=2'd1, HOLD=2'd2);
  - the reset PC constant, shared with the next-PC logic and the testbench.
- One sub-module, if_id_reg: holds {ins, PC_plus_4, valid} with load/hold/bubble controls. Hold has priority over bubble.
- FSM, PC, buf and redir live in if_fetch.

## Test plan
- Reset, zero-wait memory returning ins = word address: id_valid rises 1 cycle after reset release. The id_PC_plus_4 sequence is 0xC01, 0xC02, 0xC03…
- Memory with 3-cycle ack latency: imem_addr stays stable at 0xC00 for 3 cycles. Only one id_valid pulse per ack; bubbles in between.
- stall=1 for 4 cycles, asserted in the same cycle as an ack: state goes to HOLD and imem_req=0. After release, the buffered instruction appears once and PC advances by 1.
- flush with NPC=0xD00 while a 3-cycle request for 0xC05 is outstanding: state goes to DROP. The ack for 0xC05 produces no id_valid. The next imem_addr is 0xD00.
- flush and stall both high: flush is ignored and state/PC are unchanged. With flush still high after stall drops, the redirect happens.
- PC=0x3FFF_FFFF fetched: id_PC_plus_4=0. rst pulsed mid-request: PC=0xC00, id_valid=0 asynchronously.
